mmcm_fineps_sequencer: RTL
==========================

// Module: mmcm_fineps_sequencer
// PURPOSE
// Multi-step fine phase-shift controller for an MMCME2_ADV dynamic phase-shift port. It accepts relative
// (signed step count) or absolute (target position) requests over a valid/ready handshake, then issues one
// PSEN pulse per step and waits for PSDONE before the next. It tracks the current phase position modulo one
// output-clock period and flags timeout and unlock errors. Sits in the PSCLK domain beside clock_synthesizer.
// PARAMETERS
// INT_STEPS_PER_PERIOD  112  fine-PS steps per CLKOUT period (56 * CLKOUT_DIVIDE); position wraps here
// INT_REQ_W             16   width of in_req_value (signed in relative mode, unsigned in absolute mode)
// INT_TIMEOUT_CYCLES    64   max in_clk cycles from PSEN to PSDONE before timeout error
// INT_POS_W             $clog2(INT_STEPS_PER_PERIOD), derived, not overridable
// PORTS
// in_clk            in   1          phase-shift clock; also drives MMCM PSCLK
// in_rst_n          in   1          asynchronous reset, active low
// in_mmcm_locked    in   1          MMCM LOCKED, synchronous to in_clk
// in_req_valid      in   1          request valid
// out_req_ready     out  1          request ready
// in_req_abs        in   1          0: relative steps; 1: absolute target position
// in_req_value      in   INT_REQ_W  step count (signed) or target position (unsigned)
// out_psen          out  1          to MMCM PSEN
// out_psincdec      out  1          to MMCM PSINCDEC (1 = increment)
// in_psdone         in   1          from MMCM PSDONE
// out_busy          out  1          high from acceptance until completion or abort
// out_done          out  1          one-cycle pulse when a request completes
// out_pos           out  INT_POS_W  current phase position, 0..INT_STEPS_PER_PERIOD-1
// out_err_timeout   out  1          sticky: PSDONE missing within INT_TIMEOUT_CYCLES
// out_err_unlock    out  1          sticky: lock lost while busy
// out_err_range     out  1          one-cycle pulse: absolute target >= INT_STEPS_PER_PERIOD, request dropped
// in_err_clr        in   1          clears sticky errors; leaves ERROR state
// BEHAVIOUR
// Reset: all outputs 0, state IDLE, pos 0, remaining 0.
// out_req_ready = (state==IDLE) & in_mmcm_locked. Accept on valid&ready in cycle T.
// Relative: remaining=|value|, dir=(value>0). Absolute: delta=target-pos; if delta>N/2 then delta-=N;
//   if delta<-N/2 then delta+=N (N=INT_STEPS_PER_PERIOD); delta==N/2 goes positive; then as relative.
// remaining==0 at acceptance: out_done pulse at T+1, no PSEN, back to IDLE.
// Out-of-range absolute target: out_err_range pulse at T+1, no motion, no out_done.
// States: IDLE -> ISSUE -> WAIT_DONE -> (ISSUE | DONE) -> IDLE; ERROR on timeout.
// ISSUE: out_psen=1 for exactly one cycle (T+1 for first step), out_psincdec=dir held stable while busy;
//   timeout counter cleared.
// WAIT_DONE: on in_psdone: pos += dir?+1:-1, wrapping N-1<->0; remaining--; remaining==0 -> DONE, else ISSUE
//   next cycle. Counter reaches INT_TIMEOUT_CYCLES without PSDONE -> ERROR, out_err_timeout=1.
// DONE: out_done=1 for one cycle, busy=0 next cycle, IDLE.
// ERROR: ready=0, busy=0; in_err_clr -> IDLE, clears sticky flags; pos unchanged.
// in_mmcm_locked low in any state: next state IDLE, pos=0, remaining=0, psen=0; out_err_unlock=1 if busy.
//   Unlock has priority over psdone and timeout in the same cycle.
// in_psdone outside WAIT_DONE is ignored (no pos change). in_err_clr outside ERROR clears flags only.
// in_req_value magnitude unbounded: multi-period moves allowed; pos wraps each period.
// STRUCTURE
// Package mmcm_fineps_pkg: state enum (IDLE, ISSUE, WAIT_DONE, DONE, ERROR), shortest-path delta function
//   parameterised by N, direction constants.
// Single module; no sub-module. Shared with clock_synthesizer via its fineps ports (PSEN/PSINCDEC/PSDONE).
// TESTING
// MMCM PS model returns PSDONE 12 cycles after PSEN.
// Relative +3 from pos 0 -> 3 PSEN pulses, incdec=1, out_pos 3, one out_done; busy spans all.
// Relative -2 from pos 0 -> incdec=0, out_pos 110 (wrap), out_done once.
// Absolute 100 from pos 3 -> delta -15, 15 decrement pulses, out_pos 100; absolute 56 from 0 -> +56.
// Model withholds PSDONE -> out_err_timeout at PSEN+64, ready low; in_err_clr -> ready high, pos kept.
// Locked drops during a 10-step move -> psen stops, out_pos 0, out_err_unlock=1, ready low until relock.
// Relative 0 -> out_done at T+1, no PSEN; absolute 112 -> out_err_range pulse, no out_done, pos unchanged.

Source files
------------

// File: rtl/mmcm_fineps_pkg.sv
// Shared types and helpers for the MMCM fine phase-shift sequencer.
// The FSM states, step directions and the shortest-path phase delta all live here.
package mmcm_fineps_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ISSUE     = 3'd1,
    WAIT_DONE = 3'd2,
    DONE      = 3'd3,
    ERROR     = 3'd4
  } fineps_state_t;

  localparam logic DIR_INC = 1'b1;
  localparam logic DIR_DEC = 1'b0;

  // Signed step count from pos to target, taking the short way round a ring of n steps.
  // A tie at +n/2 stays positive, while -n/2 stays negative.
  function automatic int fineps_shortest_delta(input int target, input int pos, input int n);
    int d;
    d = target - pos;
    if (d > n / 2) begin
      d = d - n;
    end else if (d < -(n / 2)) begin
      d = d + n;
    end
    return d;
  endfunction

endpackage

// File: rtl/mmcm_fineps_sequencer.sv
// Multi-step fine phase-shift controller for the MMCME2_ADV dynamic phase-shift port (PSCLK domain).
// It issues one PSEN pulse per step, waits for PSDONE, tracks the position modulo one period and flags errors.
//
// state     | meaning
// IDLE      | waiting for a request; ready while the MMCM is locked
// ISSUE     | PSEN high for this single cycle; the timeout timer is loaded
// WAIT_DONE | waiting for PSDONE; moves the position on it; times out if PSDONE never arrives
// DONE      | out_done pulse; busy drops on leaving
// ERROR     | PSDONE timeout; holds here until in_err_clr
module mmcm_fineps_sequencer
  import mmcm_fineps_pkg::*;
#(
  parameter  int INT_STEPS_PER_PERIOD = 112,
  parameter  int INT_REQ_W            = 16,
  parameter  int INT_TIMEOUT_CYCLES   = 64,
  localparam int INT_POS_W            = $clog2(INT_STEPS_PER_PERIOD)
) (
  input  logic                 in_clk,
  input  logic                 in_rst_n,
  input  logic                 in_mmcm_locked,
  input  logic                 in_req_valid,
  output logic                 out_req_ready,
  input  logic                 in_req_abs,
  input  logic [INT_REQ_W-1:0] in_req_value,
  output logic                 out_psen,
  output logic                 out_psincdec,
  input  logic                 in_psdone,
  output logic                 out_busy,
  output logic                 out_done,
  output logic [INT_POS_W-1:0] out_pos,
  output logic                 out_err_timeout,
  output logic                 out_err_unlock,
  output logic                 out_err_range,
  input  logic                 in_err_clr
);

  localparam int TMR_W = $clog2(INT_TIMEOUT_CYCLES + 1);
  // The PSEN cycle and the terminal-count cycle both count toward the budget, hence the -2.
  localparam logic [TMR_W-1:0]     TMR_LOAD = TMR_W'(INT_TIMEOUT_CYCLES - 2);
  localparam logic [INT_POS_W-1:0] POS_MAX  = INT_POS_W'(INT_STEPS_PER_PERIOD - 1);

  fineps_state_t        r_state;
  logic [INT_POS_W-1:0] r_pos;
  logic [INT_REQ_W-1:0] r_remaining;
  logic [TMR_W-1:0]     r_timer;
  logic                 r_dir;
  logic                 r_psen;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_err_timeout;
  logic                 r_err_unlock;
  logic                 r_err_range;

  logic                 w_accept;
  logic                 w_range_bad;
  logic                 w_dir;
  logic [INT_REQ_W-1:0] w_steps;
  logic [INT_POS_W-1:0] w_pos_next;
  int                   w_abs_delta;

  assign out_req_ready = (r_state == IDLE) & in_mmcm_locked;
  assign w_accept      = in_req_valid & out_req_ready;
  assign w_range_bad   = in_req_abs & (int'(in_req_value) >= INT_STEPS_PER_PERIOD);

  always_comb begin
    w_abs_delta = fineps_shortest_delta(int'(in_req_value), int'(r_pos), INT_STEPS_PER_PERIOD);
    w_dir       = DIR_DEC;
    w_steps     = '0;
    if (in_req_abs) begin
      w_dir   = (w_abs_delta > 0) ? DIR_INC : DIR_DEC;
      w_steps = INT_REQ_W'((w_abs_delta < 0) ? -w_abs_delta : w_abs_delta);
    end else begin
      w_dir   = (!in_req_value[INT_REQ_W-1] && (in_req_value != '0)) ? DIR_INC : DIR_DEC;
      w_steps = in_req_value[INT_REQ_W-1] ? (~in_req_value + 1'b1) : in_req_value;
    end
  end

  always_comb begin
    w_pos_next = r_pos;
    if (r_dir == DIR_INC) begin
      w_pos_next = (r_pos == POS_MAX) ? '0 : r_pos + 1'b1;
    end else begin
      w_pos_next = (r_pos == '0) ? POS_MAX : r_pos - 1'b1;
    end
  end

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      r_state       <= IDLE;
      r_pos         <= '0;
      r_remaining   <= '0;
      r_timer       <= '0;
      r_dir         <= DIR_DEC;
      r_psen        <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_err_timeout <= 1'b0;
      r_err_unlock  <= 1'b0;
      r_err_range   <= 1'b0;
    end else begin
      r_psen      <= 1'b0;
      r_done      <= 1'b0;
      r_err_range <= 1'b0;
      if (in_err_clr) begin
        r_err_timeout <= 1'b0;
        r_err_unlock  <= 1'b0;
      end

      // Losing lock overrides everything, including a PSDONE or timeout in the same cycle.
      if (!in_mmcm_locked) begin
        r_state     <= IDLE;
        r_pos       <= '0;
        r_remaining <= '0;
        r_busy      <= 1'b0;
        if (r_busy) begin
          r_err_unlock <= 1'b1;
        end
      end else begin
        case (r_state)
          IDLE: begin
            if (w_accept) begin
              if (w_range_bad) begin
                r_err_range <= 1'b1;
              end else begin
                r_dir       <= w_dir;
                r_remaining <= w_steps;
                r_busy      <= 1'b1;
                if (w_steps == '0) begin
                  r_state <= DONE;
                  r_done  <= 1'b1;
                end else begin
                  r_state <= ISSUE;
                  r_psen  <= 1'b1;
                end
              end
            end
          end
          ISSUE: begin
            r_timer <= TMR_LOAD;
            r_state <= WAIT_DONE;
          end
          WAIT_DONE: begin
            if (in_psdone) begin
              r_pos       <= w_pos_next;
              r_remaining <= r_remaining - 1'b1;
              if (r_remaining == INT_REQ_W'(1)) begin
                r_state <= DONE;
                r_done  <= 1'b1;
              end else begin
                r_state <= ISSUE;
                r_psen  <= 1'b1;
              end
            end else if (r_timer == '0) begin
              r_state       <= ERROR;
              r_err_timeout <= 1'b1;
              r_busy        <= 1'b0;
            end else begin
              r_timer <= r_timer - 1'b1;
            end
          end
          DONE: begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
          ERROR: begin
            if (in_err_clr) begin
              r_state <= IDLE;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign out_psen        = r_psen;
  assign out_psincdec    = r_dir;
  assign out_busy        = r_busy;
  assign out_done        = r_done;
  assign out_pos         = r_pos;
  assign out_err_timeout = r_err_timeout;
  assign out_err_unlock  = r_err_unlock;
  assign out_err_range   = r_err_range;

endmodule
